imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder sitting on the far side of the program counter's 8-bit address bus. It accepts fetch addresses through a valid/ready request channel and returns the addressed 32-bit instruction one cycle later through a valid/ready response channel, with back-to-back throughput of one fetch per cycle. A byte-serial loader port fills memory before or between program runs.

## Interface
- DATA_W, 32, instruction width; must be a multiple of 8
- ADDR_W, 8, fetch address width (matches PC output)
- DEPTH, 256, number of instruction words, at most 2^ADDR_W
- NOP_WORD, 32'h0000_0000, value returned for out-of-range addresses
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- req_addr  in  ADDR_W  fetch address from the PC
- req_valid  in  1  fetch request present
- req_ready  out  1  responder accepts a request this cycle
- rsp_instr  out  DATA_W  fetched instruction
- rsp_err  out  1  address ≥ DEPTH; qualified by rsp_valid
- rsp_valid  out  1  response held on rsp_instr and rsp_err
- rsp_ready  in  1  consumer takes the response
- load_en  in  1  loader mode; blocks new fetches
- load_byte  in  8  program byte, little-endian within each word
- load_valid  in  1  load_byte valid this cycle
- load_ptr  out  ADDR_W  next word index the loader writes

## Operation
- Two-state FSM: FETCH, the reset state, and LOAD.
  - FETCH→LOAD when load_en=1.
  - LOAD→FETCH when load_en=0.
- req_ready = (state==FETCH) & !load_en & !reset & (!rsp_valid | rsp_ready).
- A fetch is accepted on req_valid & req_ready.
  - The accepted address is registered and the word is read.
  - The next cycle: rsp_valid=1, rsp_instr=mem[addr], rsp_err=0.
  - If addr ≥ DEPTH: rsp_instr=NOP_WORD, rsp_err=1.
- rsp_valid, rsp_instr and rsp_err stay stable until the cycle rsp_valid & rsp_ready.
  - In that cycle a new accepted request reloads them: back-to-back.
  - With no new request, rsp_valid clears.
- Loader:
  - Each load_valid cycle in LOAD shifts load_byte into a 2-bit-counted assembly register.
  - The first byte is bits [7:0].
  - The 4th byte writes the full word to mem[load_ptr], increments load_ptr and clears the byte counter.
- load_ptr wraps from DEPTH-1 to 0.
- Entering LOAD (the FETCH→LOAD transition) resets load_ptr and the byte count to 0.
- Leaving LOAD with a partial word discards the assembled bytes; nothing is written.
- load_valid is ignored in FETCH.
- req_valid is ignored while req_ready=0; the requester must hold it.
- A response pending when load_en rises stays valid and stable until consumed. No new fetch is accepted until FETCH is re-entered.
- Reset mid-load: the partial word is lost and memory words already written are kept. Memory contents are never cleared by reset; they are undefined at power-up.
- Reset values: state=FETCH, rsp_valid=0, rsp_instr=0, rsp_err=0, load_ptr=0, byte count=0. req_ready is 0 during the reset cycle.

## Timing
- Fetch latency is 1 cycle from the accepting edge to rsp_valid.
- Sustained throughput is 1 fetch per cycle while rsp_ready=1.
- Load rate is 4 load_valid cycles per word. The write lands on the edge that takes the 4th byte.
- Load-to-fetch: a word is fetchable from the first FETCH cycle after load_en falls.
- A fetch request is accepted at the earliest 1 cycle after load_en=0 is sampled.
- Memory is inferred synchronous-read with a single write port. Read and write never occur in the same cycle, because the FSM excludes it.

## Structure
- A shared package holds DATA_W/ADDR_W defaults, NOP_WORD, and the FETCH/LOAD state encoding. The CPU datapath reuses the same constants.
- Sub-module imem_ram: DEPTH×DATA_W synchronous-read RAM with one write port and no reset. It keeps the array inferable as block RAM.
- The FSM, handshake logic and loader assembly live in the top module.

## Test plan
- After reset, load 0x11,0x22,0x33,0x44 then 0xAA,0xBB,0xCC,0xDD, drop load_en, fetch addr 0 and 1 -> rsp_instr 0x44332211 then 0xDDCCBBAA, rsp_err=0, each 1 cycle after acceptance.
- Back-to-back fetches of addr 0,1,0 with rsp_ready=1 -> req_ready stays 1 and rsp_valid stays 1 for 3 consecutive cycles with matching words.
- rsp_ready=0 for 3 cycles with req_valid held -> req_ready=0 and rsp_instr stable; the held request is accepted on the cycle rsp_ready=1.
- DEPTH=16, fetch addr 0x20 -> rsp_instr=NOP_WORD, rsp_err=1.
- Load 258 words of 4 bytes each with DEPTH=256 -> load_ptr wraps to 0 and words 256 and 257 overwrite addr 0 and 1. A 2-byte partial word followed by load_en=0 leaves the memory unchanged.
- Assert reset during load byte 3 and with a response pending -> rsp_valid=0, load_ptr=0 next cycle, and earlier complete words are still fetchable.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder and CPU datapath.
`timescale 1ns/1ps
package imem_responder_pkg;

  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DEPTH  = 256;
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_LOAD  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / instruction response handshake bundle between PC and instruction memory.
`timescale 1ns/1ps
interface imem_responder_if #(
  parameter int unsigned ADDR_W = imem_responder_pkg::IMEM_ADDR_W,
  parameter int unsigned DATA_W = imem_responder_pkg::IMEM_DATA_W
) ();

  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_err;
  logic              rsp_valid;
  logic              rsp_ready;

  modport master (
    output req_addr, req_valid, rsp_ready,
    input  req_ready, rsp_instr, rsp_err, rsp_valid
  );

  modport slave (
    input  req_addr, req_valid, rsp_ready,
    output req_ready, rsp_instr, rsp_err, rsp_valid
  );

endinterface

// File: rtl/imem_ram.sv
// Single-write-port, synchronous-read instruction RAM; no reset so it maps onto block RAM.
`timescale 1ns/1ps
module imem_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; read data holds until the next read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch handshake, FETCH/LOAD control and byte-serial loader.
`timescale 1ns/1ps
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned       DATA_W   = IMEM_DATA_W,
  parameter int unsigned       ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned       DEPTH    = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  input  logic              load_en,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic [ADDR_W-1:0] load_ptr
);

  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BPW    = DATA_W / 8;
  localparam int unsigned CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BPW - 1);

  imem_state_e        state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-9:0]  asm_q, asm_d;
  logic               req_ready_c;
  logic               accept_c;
  logic               in_range_c;
  logic               ram_we_c;
  logic               ram_re_c;
  logic [DATA_W-1:0]  ram_wdata_c;
  logic [DATA_W-1:0]  ram_rdata;

  assign in_range_c = (32'(bus.req_addr) < DEPTH);

  // Next-state, handshake and loader assembly.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_wdata_c = {load_byte, asm_q};
    req_ready_c = (state_q == ST_FETCH) & ~load_en & ~reset & (~rsp_valid_q | bus.rsp_ready);
    accept_c    = bus.req_valid & req_ready_c;

    unique case (state_q)
      ST_FETCH: begin
        if (load_en) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_d = ST_FETCH;
        end else if (load_valid) begin
          // Little-endian: earlier bytes shift toward bit 0.
          asm_d = {load_byte, asm_q[DATA_W-9:8]};
          if (cnt_q == CNT_LAST) begin
            ram_we_c = ~reset;
            ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~in_range_c;
      ram_re_c    = in_range_c;
    end else if (rsp_valid_q & bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (RAM_AW'(ptr_q)),
    .wdata_i (ram_wdata_c),
    .re_i    (ram_re_c),
    .raddr_i (RAM_AW'(bus.req_addr)),
    .rdata_o (ram_rdata)
  );

  // Instruction is zero when idle, NOP for out-of-range, else the RAM read register.
  assign bus.rsp_instr = !rsp_valid_q ? '0 : (rsp_err_q ? NOP_WORD : ram_rdata);
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign load_ptr      = ptr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: load, fetch, back-to-back, stall, range, wrap, reset.
`timescale 1ns/1ps
module tb_imem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en, load_valid;
  logic [7:0] load_byte, load_ptr;
  logic       ld16_en, ld16_valid;
  logic [7:0] ld16_byte, load_ptr16;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  imem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus   ();
  imem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus16 ();

  imem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .NOP_WORD(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .load_en(load_en), .load_byte(load_byte), .load_valid(load_valid), .load_ptr(load_ptr)
  );

  imem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .NOP_WORD(32'h0000_0000)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus16),
    .load_en(ld16_en), .load_byte(ld16_byte), .load_valid(ld16_valid), .load_ptr(load_ptr16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_byte  = w[8*i +: 8];
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    settle();
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_instr"}, bus.rsp_instr, exp);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    step();
    chk({tag, "_drain"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  localparam logic [31:0] W0 = 32'h4433_2211;
  localparam logic [31:0] W1 = 32'hDDCC_BBAA;

  initial begin
    reset = 1'b1;
    load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    ld16_en = 1'b0; ld16_valid = 1'b0; ld16_byte = 8'h00;
    bus.req_addr = 8'h00; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    bus16.req_addr = 8'h00; bus16.req_valid = 1'b0; bus16.rsp_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
    chk("rst_instr", bus.rsp_instr, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_ptr", 32'(load_ptr), 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    settle();
    chk("post_rst_rdy", 32'(bus.req_ready), 32'd1);

    // Load two words, then fetch them
    load_en = 1'b1;
    step();
    chk("ld_rdy", 32'(bus.req_ready), 32'd0);
    load_word(W0);
    chk("ld_ptr1", 32'(load_ptr), 32'd1);
    load_word(W1);
    chk("ld_ptr2", 32'(load_ptr), 32'd2);
    load_en = 1'b0;
    settle();
    chk("ld_exit_rdy", 32'(bus.req_ready), 32'd0);
    step();
    fetch("f0", 8'd0, W0);
    fetch("f1", 8'd1, W1);

    // Back-to-back 0,1,0
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr  = (i == 1) ? 8'd1 : 8'd0;
      bus.req_valid = 1'b1;
      settle();
      chk("b2b_rdy", 32'(bus.req_ready), 32'd1);
      step();
      chk("b2b_vld", 32'(bus.rsp_valid), 32'd1);
      chk("b2b_instr", bus.rsp_instr, (i == 1) ? W1 : W0);
    end
    bus.req_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(bus.rsp_valid), 32'd0);

    // Consumer stall with held request
    bus.req_addr = 8'd0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    step();
    chk("st_first", bus.rsp_instr, W0);
    bus.req_addr = 8'd1; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_rdy", 32'(bus.req_ready), 32'd0);
      step();
      chk("st_vld", 32'(bus.rsp_valid), 32'd1);
      chk("st_instr", bus.rsp_instr, W0);
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("st_rel_rdy", 32'(bus.req_ready), 32'd1);
    step();
    chk("st_rel_instr", bus.rsp_instr, W1);
    bus.req_valid = 1'b0;
    step();
    chk("st_drain", 32'(bus.rsp_valid), 32'd0);

    // Range check on the 16-deep instance
    for (int i = 0; i < 3; i++) begin
      bus16.req_addr  = (i == 0) ? 8'h20 : ((i == 1) ? 8'h10 : 8'h0F);
      bus16.req_valid = 1'b1;
      settle();
      chk("rng_rdy", 32'(bus16.req_ready), 32'd1);
      step();
      bus16.req_valid = 1'b0;
      chk("rng_vld", 32'(bus16.rsp_valid), 32'd1);
      chk("rng_err", 32'(bus16.rsp_err), (i == 2) ? 32'd0 : 32'd1);
      if (i != 2) chk("rng_nop", bus16.rsp_instr, 32'h0000_0000);
      step();
    end

    // Pointer wrap over 258 words, then a discarded partial word
    load_en = 1'b1;
    step();
    for (int i = 0; i < 258; i++) begin
      load_word(32'hC0DE_0000 | 32'(i));
      if (i == 255) chk("wrap_ptr0", 32'(load_ptr), 32'd0);
    end
    chk("wrap_ptr2", 32'(load_ptr), 32'd2);
    load_valid = 1'b1; load_byte = 8'hEE;
    step();
    load_byte = 8'hFF;
    step();
    load_valid = 1'b0; load_en = 1'b0;
    step();
    fetch("wr0", 8'd0, 32'hC0DE_0100);
    fetch("wr1", 8'd1, 32'hC0DE_0101);
    fetch("wr2", 8'd2, 32'hC0DE_0002);

    // Reset mid-load with a response pending
    bus.req_addr = 8'd2; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    chk("pend_vld", 32'(bus.rsp_valid), 32'd1);
    load_en = 1'b1;
    step();
    chk("pend_hold", bus.rsp_instr, 32'hC0DE_0002);
    chk("pend_rdy", 32'(bus.req_ready), 32'd0);
    load_word(32'h1234_5678);
    chk("pend_ptr1", 32'(load_ptr), 32'd1);
    chk("pend_vld2", 32'(bus.rsp_valid), 32'd1);
    load_valid = 1'b1; load_byte = 8'h01;
    step();
    load_byte = 8'h02;
    step();
    load_byte = 8'h03; reset = 1'b1;
    step();
    reset = 1'b0; load_valid = 1'b0; load_en = 1'b0;
    chk("mr_vld", 32'(bus.rsp_valid), 32'd0);
    chk("mr_ptr", 32'(load_ptr), 32'd0);
    chk("mr_instr", bus.rsp_instr, 32'd0);
    fetch("mr0", 8'd0, 32'h1234_5678);
    fetch("mr1", 8'd1, 32'hC0DE_0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
